dm163_column_scanner: RTL and testbench
=======================================

Name: dm163_column_scanner

Overview:
- Consumer side of the 8x8 RGB pixel store. It walks the grid column by column and requests each column's 192-bit word by index.
- Each word is serialised MSB-first into the DM163 constant-current driver over SDA/SCK, latched with LAT, and displayed by driving a one-hot column enable for a fixed hold time.
- The block sits between the pixel grid read port and the ColorShield pins, and scans frames continuously while enabled.

Parameters:
- N_COLS, 8, number of columns scanned per frame.
- N_BITS, 192, bits per column (8 pixels x 24 bits).
- CLK_DIV, 4, SCK half-period in clk cycles; must be >= 1.
- LAT_CYCLES, 2, LAT high width in clk cycles; must be >= 1.
- HOLD_CYCLES, 2000, clk cycles a column stays enabled; must be >= 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, run scanning; sampled only at column boundaries.
- read_col_idx, output, 3, column index presented to the grid read port.
- col_bits, input, N_BITS, column data; combinational from the grid and valid in the same cycle as read_col_idx.
- sda, output, 1, DM163 serial data.
- sck, output, 1, DM163 shift clock; the DM163 samples SDA on the rising edge.
- lat, output, 1, DM163 latch strobe, active high.
- col_en, output, N_COLS, one-hot column drive, active high.
- frame_done, output, 1, one-cycle pulse at the end of the last column's hold.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: sda=0, sck=0, lat=0, col_en=0, frame_done=0, read_col_idx=0.
  - Internal: column counter=0, FSM=IDLE.
  - Reset mid-operation aborts any shift, latch or hold immediately.
- FSM states: IDLE, BLANK, LOAD, SHIFT, LATCH, HOLD.
- IDLE:
  - col_en=0.
  - If enable=1, go to BLANK on the next cycle.
- BLANK (1 cycle):
  - col_en=0; read_col_idx=col.
  - Next state is LOAD.
- LOAD (1 cycle):
  - Capture col_bits into a 192-bit shift register; read_col_idx is held at col.
  - Reset the bit counter to 0 and the divider to 0.
  - Next state is SHIFT.
- SHIFT:
  - Each bit occupies 2*CLK_DIV cycles: first sck=0 for CLK_DIV cycles with sda = current MSB, then sck=1 for CLK_DIV cycles with sda held.
  - At the end of the high phase, shift the register left by 1 and increment the bit counter.
  - sda changes only while sck=0.
  - After bit 191's high phase: sck=0, sda=0, go to LATCH.
  - Total SHIFT duration is N_BITS*2*CLK_DIV cycles.
- LATCH:
  - lat=1 for exactly LAT_CYCLES cycles; sck=0, col_en=0.
  - Next state is HOLD.
- HOLD:
  - col_en = 1<<col for exactly HOLD_CYCLES cycles; lat=0.
  - On the last HOLD cycle: col_en returns to 0 on the next cycle, and col increments with wrap 7->0.
  - If col was 7, frame_done=1 for that final HOLD cycle only.
  - Next state is BLANK if enable=1, otherwise IDLE (column counter retained).
- Column boundary rule: enable deassertion never truncates a column; it takes effect only at the end of HOLD.
- Per-column period is 2 + N_BITS*2*CLK_DIV + LAT_CYCLES + HOLD_CYCLES cycles.
- col_en is at most one-hot at all times, and all-zero whenever sck toggles or lat is high.
- col_bits is sampled only in LOAD; changes in any other cycle have no effect.
- Counters are sized by $clog2 of their maximum values; no overflow within legal parameter ranges.

Test Plan:
- Reset: rst_n=0 mid-SHIFT with CLK_DIV=1 -> all outputs 0 in the same cycle. After release with enable=1, the first read_col_idx is 0.
- Bit order, CLK_DIV=1, LAT_CYCLES=2, HOLD_CYCLES=16: col 0 = 192'h800...001 -> the 192 sampled sda values on sck rising edges are 1, 190 zeros, then 1. lat is high 2 cycles, then col_en=8'h01 for 16 cycles. Period is 404 cycles.
- Full frame: a distinct 24-bit pattern per column (e.g. col c pixel 0 = 24'hC0FFEE ^ c) -> captured streams match each column. col_en sequence is 01,02,04,...,80,01. frame_done pulses once per 8*404 cycles, coincident with the last cycle of col_en=8'h80.
- Enable drop: deassert enable during column 3 SHIFT -> column 3 completes its latch and hold, then IDLE with col_en=0. Re-enable -> scanning resumes at column 4.
- Divider: CLK_DIV=3 -> sck high and low phases are each 3 cycles, and sda is stable across every rising edge.
- col_bits changed every cycle outside LOAD -> the shifted stream equals the value present during LOAD.

Source files
------------

// File: rtl/dm163_column_scanner.sv
// Scans an 8x8 RGB grid column by column into a DM163 driver: fetch word, shift MSB-first, latch, hold.
// Latency: one column per 2 + N_BITS*2*CLK_DIV + LAT_CYCLES + HOLD_CYCLES cycles, column data sampled in LOAD only.
// Backpressure: none; enable is honoured only at column boundaries, so a started column always completes.
module dm163_column_scanner #(
    parameter int N_COLS      = 8,
    parameter int N_BITS      = 192,
    parameter int CLK_DIV     = 4,
    parameter int LAT_CYCLES  = 2,
    parameter int HOLD_CYCLES = 2000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    output logic [$clog2(N_COLS)-1:0] read_col_idx,
    input  logic [N_BITS-1:0]         col_bits,
    output logic                      sda,
    output logic                      sck,
    output logic                      lat,
    output logic [N_COLS-1:0]         col_en,
    output logic                      frame_done
);

    localparam int CW = $clog2(N_COLS);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(N_BITS);
    localparam int LW = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HI    = DW'(CLK_DIV);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N_BITS - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(LAT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(N_COLS - 1);

    typedef enum logic [2:0] {IDLE, BLANK, LOAD, SHIFT, LATCH, HOLD} state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [N_BITS-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [DW-1:0]     div;
    logic [LW-1:0]     lat_cnt;
    logic [HW-1:0]     hold_cnt;

    assign read_col_idx = col;

    // Outputs are registered alongside the state so each one lines up with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            div        <= '0;
            lat_cnt    <= '0;
            hold_cnt   <= '0;
            sda        <= 1'b0;
            sck        <= 1'b0;
            lat        <= 1'b0;
            col_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state <= BLANK;
                end
                BLANK: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg   <= col_bits;
                    bit_cnt <= '0;
                    div     <= '0;
                    sda     <= col_bits[N_BITS-1];
                    sck     <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (div == DIV_LAST) begin
                        shreg <= shreg << 1;
                        div   <= '0;
                        sck   <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            sda     <= 1'b0;
                            lat     <= 1'b1;
                            lat_cnt <= '0;
                            state   <= LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            // next MSB presented while sck goes low, so sda never moves under a high sck
                            sda     <= shreg[N_BITS-2];
                        end
                    end else begin
                        div <= div + DW'(1);
                        sck <= ((div + DW'(1)) >= DIV_HI);
                    end
                end
                LATCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        lat        <= 1'b0;
                        col_en     <= N_COLS'(1) << col;
                        hold_cnt   <= '0;
                        frame_done <= (HOLD_CYCLES == 1) && (col == COL_LAST);
                        state      <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        col_en     <= '0;
                        frame_done <= 1'b0;
                        col        <= (col == COL_LAST) ? '0 : col + CW'(1);
                        state      <= enable ? BLANK : IDLE;
                    end else begin
                        hold_cnt   <= hold_cnt + HW'(1);
                        frame_done <= (col == COL_LAST) && ((hold_cnt + HW'(1)) == HOLD_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm163_column_scanner.sv
// Directed bench: one instance at CLK_DIV=1 driven from a pixel-grid model, one at CLK_DIV=3 driven with noise.
module tb_dm163_column_scanner;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b0;
    logic         enable3 = 1'b0;
    logic [2:0]   read_col_idx, read_col_idx3;
    logic [191:0] col_bits, col_bits3;
    logic         sda, sck, lat, frame_done;
    logic         sda3, sck3, lat3, frame_done3;
    logic [7:0]   col_en, col_en3;

    logic [191:0] pattern [8];
    logic [191:0] cap, cap3;
    int           cap_n = 0;
    int           cap3_n = 0;
    int           inv_err = 0;
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    assign col_bits = pattern[read_col_idx];

    dm163_column_scanner #(.N_COLS(8), .N_BITS(192), .CLK_DIV(1), .LAT_CYCLES(2), .HOLD_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .read_col_idx(read_col_idx), .col_bits(col_bits),
        .sda(sda), .sck(sck), .lat(lat), .col_en(col_en), .frame_done(frame_done)
    );

    dm163_column_scanner #(.N_COLS(8), .N_BITS(192), .CLK_DIV(3), .LAT_CYCLES(2), .HOLD_CYCLES(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable3), .read_col_idx(read_col_idx3), .col_bits(col_bits3),
        .sda(sda3), .sck(sck3), .lat(lat3), .col_en(col_en3), .frame_done(frame_done3)
    );

    // DM163 side: shift in sda on each rising sck
    always @(posedge sck) begin
        cap   <= {cap[190:0], sda};
        cap_n <= cap_n + 1;
    end

    always @(posedge sck3) begin
        cap3   <= {cap3[190:0], sda3};
        cap3_n <= cap3_n + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (($countones(col_en) > 1) || (col_en != 0 && (lat || sck))) inv_err++;
            if (($countones(col_en3) > 1) || (col_en3 != 0 && (lat3 || sck3))) inv_err++;
        end
    end

    task automatic test_reset();
        logic seen;
        seen = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({sda, sck, lat, frame_done, col_en, read_col_idx} !== 14'h0 ||
            {sda3, sck3, lat3, frame_done3, col_en3, read_col_idx3} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %0h/%0h expected 0/0",
                     {sda, sck, lat, frame_done, col_en, read_col_idx},
                     {sda3, sck3, lat3, frame_done3, col_en3, read_col_idx3});
        end
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        vectors++;
        if (read_col_idx !== 3'd0 || col_en !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_blank: got idx %0d col_en %0h expected idx 0 col_en 0", read_col_idx, col_en);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sck) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL reset_reach_shift: got no sck high in 50 cycles expected sck high");
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({sda, sck, lat, frame_done, col_en, read_col_idx} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_mid_shift: got %0h expected 0", {sda, sck, lat, frame_done, col_en, read_col_idx});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bit_order();
        int c0;
        int lat_n = 0;
        int lat_first = -1;
        int en_n = 0;
        int en_first = -1;
        logic [191:0] exp_bits;
        exp_bits      = '0;
        exp_bits[191] = 1'b1;
        exp_bits[0]   = 1'b1;
        @(negedge clk);
        c0 = cap_n;
        vectors++;
        if (read_col_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL first_col_idx: got %0d expected 0", read_col_idx);
        end
        for (int k = 1; k < 404; k++) begin
            @(negedge clk);
            if (lat) begin
                lat_n++;
                if (lat_first < 0) lat_first = k;
            end
            if (col_en == 8'h01) begin
                en_n++;
                if (en_first < 0) en_first = k;
            end
        end
        vectors++;
        if (cap_n - c0 != 192 || cap !== exp_bits) begin
            miscompares++;
            $display("FAIL bit_order_stream: got %0d bits %0h expected 192 bits %0h", cap_n - c0, cap, exp_bits);
        end
        vectors++;
        if (lat_n != 2 || lat_first != 386) begin
            miscompares++;
            $display("FAIL bit_order_lat: got %0d cycles at %0d expected 2 cycles at 386", lat_n, lat_first);
        end
        vectors++;
        if (en_n != 16 || en_first != 388) begin
            miscompares++;
            $display("FAIL bit_order_hold: got %0d cycles at %0d expected 16 cycles at 388", en_n, en_first);
        end
    endtask

    task automatic test_full_frame();
        int c;
        int c0;
        int fd_total = 0;
        int fd_col = -1;
        int fd_at = -1;
        logic [7:0] en388, en403;
        for (int i = 0; i < 8; i++) pattern[i] = {24'hC0FFEE ^ 24'(i), 160'h0, 8'hA0 | 8'(i)};
        for (int idx = 0; idx < 8; idx++) begin
            c = (idx + 1) % 8;
            @(negedge clk);
            c0 = cap_n;
            vectors++;
            if (read_col_idx !== 3'(c)) begin
                miscompares++;
                $display("FAIL frame_col_idx: got %0d expected %0d", read_col_idx, c);
            end
            for (int k = 1; k < 404; k++) begin
                @(negedge clk);
                if (frame_done) begin
                    fd_total++;
                    fd_col = c;
                    fd_at  = k;
                end
                if (k == 388) en388 = col_en;
                if (k == 403) en403 = col_en;
            end
            vectors++;
            if (cap_n - c0 != 192 || cap !== pattern[c]) begin
                miscompares++;
                $display("FAIL frame_stream col %0d: got %0h expected %0h", c, cap, pattern[c]);
            end
            vectors++;
            if (en388 !== 8'(1 << c) || en403 !== 8'(1 << c)) begin
                miscompares++;
                $display("FAIL frame_col_en col %0d: got %0h/%0h expected %0h", c, en388, en403, 8'(1 << c));
            end
        end
        vectors++;
        if (fd_total != 1 || fd_col != 7 || fd_at != 403) begin
            miscompares++;
            $display("FAIL frame_done: got %0d pulses col %0d offset %0d expected 1 pulse col 7 offset 403",
                     fd_total, fd_col, fd_at);
        end
    endtask

    task automatic test_enable_drop();
        int lat_n = 0;
        int idle_bad = 0;
        logic [7:0] en403;
        repeat (808) @(negedge clk);
        @(negedge clk);
        vectors++;
        if (read_col_idx !== 3'd3) begin
            miscompares++;
            $display("FAIL drop_col3: got %0d expected 3", read_col_idx);
        end
        repeat (100) @(negedge clk);
        enable = 1'b0;
        for (int k = 101; k < 404; k++) begin
            @(negedge clk);
            if (lat) lat_n++;
            if (k == 403) en403 = col_en;
        end
        vectors++;
        if (lat_n != 2 || en403 !== 8'h08) begin
            miscompares++;
            $display("FAIL drop_completes: got lat %0d col_en %0h expected lat 2 col_en 08", lat_n, en403);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (col_en !== 8'h00 || lat !== 1'b0 || sck !== 1'b0 || read_col_idx !== 3'd4) idle_bad++;
        end
        vectors++;
        if (idle_bad != 0) begin
            miscompares++;
            $display("FAIL drop_idle: got %0d non-idle cycles expected 0", idle_bad);
        end
        enable = 1'b1;
        @(negedge clk);
        vectors++;
        if (read_col_idx !== 3'd4) begin
            miscompares++;
            $display("FAIL resume_col: got %0d expected 4", read_col_idx);
        end
        repeat (388) @(negedge clk);
        vectors++;
        if (col_en !== 8'h10) begin
            miscompares++;
            $display("FAIL resume_col_en: got %0h expected 10", col_en);
        end
        enable = 1'b0;
    endtask

    task automatic test_divider_noise();
        int c0;
        int rises = 0;
        int run = 0;
        int run_bad = 0;
        int sda_bad = 0;
        logic started = 1'b0;
        logic prev_sck = 1'b0;
        logic prev_sda = 1'b0;
        logic [191:0] exp_bits;
        exp_bits = '0;
        @(negedge clk);
        c0        = cap3_n;
        col_bits3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        enable3   = 1'b1;
        for (int k = 1; k < 1170; k++) begin
            @(negedge clk);
            col_bits3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            // LOAD is the second cycle after enable is taken; this is the value it captures
            if (k == 2) exp_bits = col_bits3;
            if (sck3 && !prev_sck) begin
                rises++;
                if (sda3 !== prev_sda) sda_bad++;
                if (started && run != 3) run_bad++;
                started = 1'b1;
                run     = 1;
            end else if (!sck3 && prev_sck) begin
                if (run != 3) run_bad++;
                run = 1;
            end else begin
                run++;
                if (sck3 && sda3 !== prev_sda) sda_bad++;
            end
            prev_sck = sck3;
            prev_sda = sda3;
        end
        enable3 = 1'b0;
        vectors++;
        if (rises != 192 || run_bad != 0) begin
            miscompares++;
            $display("FAIL divider_phases: got %0d rises %0d bad runs expected 192 rises 0 bad runs", rises, run_bad);
        end
        vectors++;
        if (sda_bad != 0) begin
            miscompares++;
            $display("FAIL divider_sda_stable: got %0d changes expected 0", sda_bad);
        end
        vectors++;
        if (cap3_n - c0 != 192 || cap3 !== exp_bits) begin
            miscompares++;
            $display("FAIL load_only_sample: got %0h expected %0h", cap3, exp_bits);
        end
    endtask

    initial begin
        col_bits3 = '0;
        for (int i = 0; i < 8; i++) pattern[i] = '0;
        pattern[0][191] = 1'b1;
        pattern[0][0]   = 1'b1;
        test_reset();
        test_bit_order();
        test_full_frame();
        test_enable_drop();
        test_divider_noise();
        vectors++;
        if (inv_err != 0) begin
            miscompares++;
            $display("FAIL col_en_invariant: got %0d violations expected 0", inv_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
